// File: rtl/mole_game_core.sv
// Whack-a-mole game sequencer: LFSR-chosen moles, timed rounds, score and
// best-score tracking, and registered one-cycle hit/miss strobes for sound.
module mole_game_core #(
  parameter int         NUM_MOLES     = 4,
  parameter int         SCORE_W       = 8,
  parameter int         TICKS_PER_SEC = 50000000,
  parameter int         GAME_SECS     = 30,
  parameter int         MOLE_TICKS    = 25000000,
  parameter int         GAP_TICKS     = 5000000,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [1:0]           state,
  output logic [NUM_MOLES-1:0] mole_onehot,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   high_score,
  output logic [7:0]           secs_left,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic                 game_over
);
  localparam logic [1:0] S_IDLE = 2'd0, S_GAP = 2'd1, S_SHOW = 2'd2, S_OVER = 2'd3;
  localparam int IDX_W  = $clog2(NUM_MOLES);
  localparam int SEC_W  = $clog2(TICKS_PER_SEC + 1);
  localparam int MOLE_W = $clog2(MOLE_TICKS + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [MOLE_W-1:0] MOLE_LAST = MOLE_W'(MOLE_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [IDX_W:0]    NM_EXT    = NUM_MOLES[IDX_W:0];
  localparam logic [IDX_W:0]    ONE_EXT   = 1;
  localparam logic [7:0]        SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [1:0]           state_q, state_next;
  logic                 start_q;
  logic [NUM_MOLES-1:0] hit_q, hit_edge, act_mask;
  logic                 start_edge, right_edge, wrong_edge;
  logic [7:0]           lfsr;
  logic [IDX_W-1:0]     mole_idx, new_idx;
  logic [IDX_W:0]       fold;
  logic                 prev_valid;
  logic [SEC_W-1:0]     sec_cnt;
  logic [MOLE_W-1:0]    mole_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 sec_tick, expire, go_start, load_mole, do_hit, do_miss, do_wrong;

  assign start_edge = start & ~start_q;
  assign hit_edge   = hit & ~hit_q;
  assign act_mask   = {{(NUM_MOLES-1){1'b0}}, 1'b1} << mole_idx;
  assign right_edge = |(hit_edge & act_mask);
  assign wrong_edge = |(hit_edge & ~act_mask);
  assign state      = state_q;

  // Fold the raw LFSR bits into range, then step past the previous mole.
  always_comb begin
    fold = {1'b0, lfsr[IDX_W-1:0]};
    if (fold >= NM_EXT) fold = fold - NM_EXT;
    if (prev_valid && fold[IDX_W-1:0] == mole_idx)
      fold = ((fold + ONE_EXT) == NM_EXT) ? '0 : fold + ONE_EXT;
    new_idx = fold[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_next;
  end

  // Game-clock expiry outranks any hit or timeout in the same cycle.
  always_comb begin
    state_next = state_q;
    go_start   = 1'b0;
    load_mole  = 1'b0;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    do_wrong   = 1'b0;
    sec_tick   = (state_q == S_GAP || state_q == S_SHOW) && (sec_cnt == SEC_LAST);
    expire     = sec_tick && (secs_left == 8'd1);
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_next = S_GAP;
          go_start   = 1'b1;
        end
      end
      S_GAP: begin
        if (expire) state_next = S_OVER;
        else if (gap_cnt == GAP_LAST) begin
          state_next = S_SHOW;
          load_mole  = 1'b1;
        end
      end
      S_SHOW: begin
        if (expire) state_next = S_OVER;
        else if (wrong_edge) do_wrong = 1'b1;
        else if (right_edge) begin
          do_hit     = 1'b1;
          state_next = S_GAP;
        end else if (mole_cnt == MOLE_LAST) begin
          do_miss    = 1'b1;
          state_next = S_GAP;
        end
      end
    endcase
  end

  always_comb begin
    mole_onehot = '0;
    if (state_q == S_SHOW) mole_onehot = act_mask;
    game_over = (state_q == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= start;
      hit_q      <= hit;
      lfsr       <= SEED;
      mole_idx   <= '0;
      prev_valid <= 1'b0;
      score      <= '0;
      high_score <= '0;
      secs_left  <= '0;
      sec_cnt    <= '0;
      mole_cnt   <= '0;
      gap_cnt    <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      start_q    <= start;
      hit_q      <= hit;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      hit_pulse  <= do_hit;
      miss_pulse <= do_wrong | do_miss;
      gap_cnt    <= (state_q == S_GAP && state_next == S_GAP) ? gap_cnt + 1'b1 : '0;
      // A wrong button freezes the mole timer for that cycle.
      if (state_q == S_SHOW && state_next == S_SHOW)
        mole_cnt <= do_wrong ? mole_cnt : mole_cnt + 1'b1;
      else
        mole_cnt <= '0;
      if (load_mole) begin
        mole_idx   <= new_idx;
        prev_valid <= 1'b1;
      end
      if (go_start) begin
        score     <= '0;
        secs_left <= 8'(GAME_SECS);
        sec_cnt   <= '0;
      end else if (state_q == S_GAP || state_q == S_SHOW) begin
        if (sec_tick) begin
          sec_cnt   <= '0;
          secs_left <= secs_left - 8'd1;
        end else begin
          sec_cnt <= sec_cnt + 1'b1;
        end
      end
      if (do_hit && score != {SCORE_W{1'b1}}) score <= score + 1'b1;
      if (do_wrong && score != '0) score <= score - 1'b1;
      if (expire && score > high_score) high_score <= score;
    end
  end
endmodule

// File: doc/mole_game_core.md
MOLE_GAME_CORE -- requirements
Module: mole_game_core

Interface
REQ-001 SHALL have parameter NUM_MOLES, default 4, meaning number of mole positions and hit buttons (legal 2..8).
REQ-002 SHALL have parameter SCORE_W, default 8, meaning width of score and high_score.
REQ-003 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clk cycles per game second.
REQ-004 SHALL have parameter GAME_SECS, default 30, meaning game length in seconds (1..255).
REQ-005 SHALL have parameter MOLE_TICKS, default 25000000, meaning clk cycles a mole stays up.
REQ-006 SHALL have parameter GAP_TICKS, default 5000000, meaning blank cycles between moles.
REQ-007 SHALL have parameter LFSR_SEED, default 8'hA5, meaning LFSR reset value.
REQ-008 clk  input  1  system clock; single clock domain.
REQ-009 reset  input  1  reset; synchronous, active-high.
REQ-010 start  input  1  level; a rising edge starts a game.
REQ-011 hit  input  NUM_MOLES  debounced button levels, active-high, one bit per mole.
REQ-012 state  output  2  IDLE=0, GAP=1, SHOW=2, OVER=3.
REQ-013 mole_onehot  output  NUM_MOLES  active mole, one-hot in SHOW, zero otherwise.
REQ-014 score  output  SCORE_W  current score.
REQ-015 high_score  output  SCORE_W  best score since reset.
REQ-016 secs_left  output  8  remaining seconds.
REQ-017 hit_pulse / miss_pulse  output  1 each  one-cycle event strobes for the sound generator.
REQ-018 game_over  output  1  high while state==OVER.

Function
REQ-019 Rising edges of start and of each hit bit SHALL be detected against a registered previous value; only edges act, held levels never repeat.
REQ-020 IDLE: start edge -> score=0, secs_left=GAME_SECS, second-tick counter=0, next state GAP.
REQ-021 GAP: count GAP_TICKS cycles, then load mole index and enter SHOW with the mole counter=0.
REQ-022 Mole index: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advancing every cycle; idx = low clog2(NUM_MOLES) bits, minus NUM_MOLES if >= NUM_MOLES; if idx equals the previous mole, use idx+1 wrapping to 0.
REQ-023 SHOW, hit edge on the active mole only -> score+1 saturating at 2^SCORE_W-1, hit_pulse=1, next state GAP.
REQ-024 SHOW, hit edge on any inactive mole (including the same cycle as an active-mole edge) -> score-1 floored at 0, miss_pulse=1, remain SHOW, mole counter unchanged.
REQ-025 SHOW, mole counter reaches MOLE_TICKS-1 with no hit -> miss_pulse=1, score unchanged, next state GAP.
REQ-026 In GAP and SHOW, a counter SHALL decrement secs_left once every TICKS_PER_SEC cycles; in IDLE/OVER it is frozen.
REQ-027 The cycle secs_left goes 1->0 SHALL force next state OVER, overriding any hit or timeout in that cycle (no score change, no pulses).
REQ-028 On entering OVER, high_score SHALL load score if score > high_score; equal score leaves it unchanged.
REQ-029 OVER: mole_onehot=0, score held; start edge behaves as in IDLE (REQ-020).
REQ-030 hit edges in IDLE, GAP and OVER SHALL be ignored (no pulses, no score change).
REQ-031 start edges while in GAP or SHOW SHALL be ignored.
REQ-032 hit_pulse and miss_pulse SHALL never be high in the same cycle and SHALL be registered outputs.

Reset
REQ-033 reset=1 at a clk edge -> state=IDLE, mole_onehot=0, score=0, high_score=0, secs_left=0, pulses=0, game_over=0, all counters 0, LFSR=LFSR_SEED (forced to 8'h01 if seed is 0).
REQ-034 Edge-detect registers SHALL load the current start/hit values during reset, so a button held through reset release creates no edge.
REQ-035 reset mid-game SHALL abort immediately, with no high_score update.

Verification (NUM_MOLES=4, TICKS_PER_SEC=10, GAME_SECS=3, MOLE_TICKS=8, GAP_TICKS=2)
REQ-036 Start edge from IDLE -> state=GAP next cycle, secs_left=3; 2 cycles later state=SHOW with exactly one mole_onehot bit set.
REQ-037 In SHOW, pulse the active hit bit -> one cycle later hit_pulse=1, score=1, state=GAP; holding the bit causes no second increment.
REQ-038 At score=2, pulse an inactive bit -> miss_pulse=1, score=1, state stays SHOW; pulse active+inactive together -> miss only, score=0; a further wrong pulse keeps score=0.
REQ-039 No hits -> each mole times out after 8 cycles with miss_pulse; after 30 cycles from start, state=OVER, game_over=1, secs_left=0; a hit on the expiry cycle is ignored.
REQ-040 Game 1 ends with score 3 -> high_score=3; game 2 ends with 2 -> high_score stays 3; reset asserted during game 3 -> all outputs at REQ-033 values, high_score=0.
REQ-041 Over 200 consecutive moles, the same index never appears twice in a row and every index 0..3 appears.
